// File: rtl/phased_delay_pkg.sv
// Shared definitions for the phased delay array: angle encoding, delay line
// depth and the beam steering FSM state type.
package phased_delay_pkg;

  localparam int NUM_ANGLES  = 13;
  localparam int DELAY_DEPTH = 8501;

  typedef logic [3:0] angle_t;

  localparam angle_t ANGLE_ZERO = 4'd6;
  localparam angle_t ANGLE_MAX  = angle_t'(NUM_ANGLES - 1);

  typedef enum logic [1:0] {ACTIVE, WAIT_GAP, BLANK} state_t;

  // Switch codes 13..15 have no angle; treat them as boresight.
  function automatic angle_t clamp_angle(input angle_t a);
    return (a > ANGLE_MAX) ? ANGLE_ZERO : a;
  endfunction

  // Sweep order 0..12 then back to 0.
  function automatic angle_t next_angle(input angle_t a);
    return (a == ANGLE_MAX) ? '0 : a + 4'd1;
  endfunction

endpackage

// File: rtl/beam_steer_controller_if.sv
// Control/status bundle between the beam steering controller and its user.
//   sw_select      raw select switches (async)
//   sweep_en       1 = auto sweep (async)
//   pwm_in         source PWM feeding the delay line (async)
//   angle_sel      committed angle select, 0..12
//   out_en         1 = array outputs enabled
//   change_pending 1 while a change is waiting for a gap or blanking
//   sweep_wrap     one-cycle pulse on sweep wrap 12 -> 0
interface beam_steer_controller_if;
  import phased_delay_pkg::*;

  logic [3:0] sw_select;
  logic       sweep_en;
  logic       pwm_in;
  angle_t     angle_sel;
  logic       out_en;
  logic       change_pending;
  logic       sweep_wrap;

  modport master (
    output sw_select, sweep_en, pwm_in,
    input  angle_sel, out_en, change_pending, sweep_wrap
  );

  modport slave (
    input  sw_select, sweep_en, pwm_in,
    output angle_sel, out_en, change_pending, sweep_wrap
  );

endinterface

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus stability filter for a bus of switches.
//   clk, rst   clock, async active-high reset
//   raw_i      asynchronous switch inputs
//   stable_o   last value that held unchanged for CYCLES synchronised cycles
module switch_debouncer #(
  parameter int               WIDTH     = 4,
  parameter int               CYCLES    = 500000,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o
);

  localparam int             CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0]  LAST = CW'(CYCLES - 1);

  logic [1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]      cand_q;
  logic [WIDTH-1:0]      stable_q;
  logic [CW-1:0]         cnt_q;

  // Sync flops reset to RESET_VAL so leaving reset never looks like a change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= {2{RESET_VAL}};
      cand_q   <= RESET_VAL;
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      if (sync_q[1] != cand_q) begin
        cand_q <= sync_q[1];
        cnt_q  <= '0;
      end else if (cnt_q == LAST) begin
        stable_q <= cand_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/beam_steer_controller.sv
// Beam angle sequencer for the 20-channel phased delay array. Picks the target
// angle from debounced switches or an auto-sweep timer, commits it only in a
// PWM low gap (or after a timeout), then blanks the outputs until the delay
// line has flushed.
//   clk, rst   50 MHz clock, async active-high reset
//   bus        beam_steer_controller_if.slave (switches, sweep, PWM in;
//              angle_sel, out_en, change_pending, sweep_wrap out)
module beam_steer_controller
  import phased_delay_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DWELL_CYCLES    = 50000000,
  parameter int FLUSH_CYCLES    = DELAY_DEPTH,
  parameter int GAP_TIMEOUT     = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  beam_steer_controller_if.slave   bus
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int GW = (GAP_TIMEOUT  > 1) ? $clog2(GAP_TIMEOUT)  : 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_TIMEOUT - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  // Synchronisers for the single-bit async inputs
  logic [1:0] sweep_sync_q, pwm_sync_q;
  logic       sweep_prev_q;
  logic       sweep_s, pwm_s, sweep_edge;

  logic [3:0] deb_sw;

  state_t        state_q,  state_d;
  angle_t        angle_q,  angle_d;
  angle_t        target_q, target_d;
  logic          out_en_q, out_en_d;
  logic          pend_q,   pend_d;
  logic          wrap_q,   wrap_d;
  logic [DW-1:0] dwell_q,  dwell_d;
  logic [GW-1:0] gap_q,    gap_d;
  logic [FW-1:0] flush_q,  flush_d;

  switch_debouncer #(
    .WIDTH     (4),
    .CYCLES    (DEBOUNCE_CYCLES),
    .RESET_VAL (ANGLE_ZERO)
  ) u_sw_deb (
    .clk      (clk),
    .rst      (rst),
    .raw_i    (bus.sw_select),
    .stable_o (deb_sw)
  );

  assign sweep_s    = sweep_sync_q[1];
  assign pwm_s      = pwm_sync_q[1];
  assign sweep_edge = sweep_s ^ sweep_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep_sync_q <= '0;
      pwm_sync_q   <= '0;
      sweep_prev_q <= 1'b0;
      state_q      <= BLANK;
      angle_q      <= ANGLE_ZERO;
      target_q     <= ANGLE_ZERO;
      out_en_q     <= 1'b0;
      pend_q       <= 1'b1;
      wrap_q       <= 1'b0;
      dwell_q      <= '0;
      gap_q        <= '0;
      flush_q      <= FLUSH_LAST;
    end else begin
      sweep_sync_q <= {sweep_sync_q[0], bus.sweep_en};
      pwm_sync_q   <= {pwm_sync_q[0], bus.pwm_in};
      sweep_prev_q <= sweep_s;
      state_q      <= state_d;
      angle_q      <= angle_d;
      target_q     <= target_d;
      out_en_q     <= out_en_d;
      pend_q       <= pend_d;
      wrap_q       <= wrap_d;
      dwell_q      <= dwell_d;
      gap_q        <= gap_d;
      flush_q      <= flush_d;
    end
  end

  // Target selection and dwell timer. The dwell only counts settled ACTIVE
  // cycles (target == angle), so every angle gets a full dwell of emission
  // regardless of how long its gap wait and blank took.
  always_comb begin
    target_d = target_q;
    dwell_d  = dwell_q;
    wrap_d   = 1'b0;
    if (!sweep_s)
      target_d = clamp_angle(deb_sw);
    if (sweep_edge) begin
      dwell_d = '0;
    end else if (sweep_s && state_q == ACTIVE && target_q == angle_q) begin
      if (dwell_q == DWELL_LAST) begin
        dwell_d  = '0;
        target_d = next_angle(target_q);
        wrap_d   = (target_q == ANGLE_MAX);
      end else begin
        dwell_d = dwell_q + DW'(1);
      end
    end
  end

  // Commit FSM. angle_sel only moves on a transition into (or within) BLANK,
  // so it can never change while outputs are enabled.
  always_comb begin
    state_d = state_q;
    angle_d = angle_q;
    gap_d   = '0;
    flush_d = flush_q;
    case (state_q)
      ACTIVE: begin
        if (target_q != angle_q)
          state_d = WAIT_GAP;
      end
      WAIT_GAP: begin
        if (target_q == angle_q) begin
          state_d = ACTIVE;
        end else if (!pwm_s || gap_q == GAP_LAST) begin
          state_d = BLANK;
          angle_d = target_q;
          flush_d = FLUSH_LAST;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      BLANK: begin
        // A new target mid-blank restarts the flush from full length.
        if (target_q != angle_q) begin
          angle_d = target_q;
          flush_d = FLUSH_LAST;
        end else if (flush_q == '0) begin
          state_d = ACTIVE;
        end else begin
          flush_d = flush_q - FW'(1);
        end
      end
      default: state_d = BLANK;
    endcase
    out_en_d = (state_d != BLANK);
    pend_d   = (state_d != ACTIVE);
  end

  assign bus.angle_sel      = angle_q;
  assign bus.out_en         = out_en_q;
  assign bus.change_pending = pend_q;
  assign bus.sweep_wrap     = wrap_q;

endmodule
